// File: rtl/dibit_frame_receiver.sv
// Dibit frame receiver.
// Hunts for a sync word on a 2-bit symbol stream, then packs the following
// symbols MSB-first into FRAME_LEN words of WORD_W bits. Each word is offered
// on a single-entry valid/ready register. A word that completes while that
// register is still occupied is dropped and flagged on the sticky overrun bit.
module dibit_frame_receiver #(
    parameter int unsigned       WORD_W    = 8,
    parameter logic [WORD_W-1:0] SYNC      = 8'hD5,
    parameter int unsigned       FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sym_valid,
    input  logic [1:0]        sym,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_end,
    output logic              in_frame,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int unsigned SymsPerWord = WORD_W / 2;
    localparam int unsigned SymCntW     = $clog2(SymsPerWord) + 1;
    localparam int unsigned WordCntW    = $clog2(FRAME_LEN) + 1;

    localparam logic [SymCntW-1:0]  LastSym  = SymCntW'(SymsPerWord - 1);
    localparam logic [WordCntW-1:0] LastWord = WordCntW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        StHunt,
        StCollect
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [SymCntW-1:0]  sym_cnt_q, sym_cnt_d;
    logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic                frame_end_q, frame_end_d;
    logic                overrun_q, overrun_d;

    logic [WORD_W-1:0]   shift_val;
    logic                complete;
    logic                last_word;
    logic                accept;
    logic                slot_free;

    // Value the shift register holds once the current symbol is in.
    assign shift_val = {shreg_q[WORD_W-3:0], sym};

    assign last_word = (word_cnt_q == LastWord);
    assign accept    = word_valid_q && word_ready;
    // Slot is free if empty, or being emptied on this same edge.
    assign slot_free = !word_valid_q || word_ready;

    // Sync hunt / word collection state machine and symbol datapath.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        sym_cnt_d  = sym_cnt_q;
        word_cnt_d = word_cnt_q;
        complete   = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (sym_valid) begin
                    shreg_d = shift_val;
                    if (shift_val == SYNC) begin
                        state_d    = StCollect;
                        shreg_d    = '0;
                        sym_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
            end

            StCollect: begin
                if (sym_valid) begin
                    shreg_d   = shift_val;
                    sym_cnt_d = sym_cnt_q + SymCntW'(1);
                    if (sym_cnt_q == LastSym) begin
                        // Dropped words still count toward the frame length.
                        complete   = 1'b1;
                        shreg_d    = '0;
                        sym_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + WordCntW'(1);
                        if (last_word) begin
                            state_d    = StHunt;
                            word_cnt_d = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = StHunt;
            end
        endcase
    end

    // Output slot: handshake, word load on completion, sticky overrun.
    always_comb begin
        word_d       = word_q;
        word_valid_d = word_valid_q;
        frame_end_d  = frame_end_q;
        overrun_d    = overrun_q;

        if (accept) begin
            word_valid_d = 1'b0;
            frame_end_d  = 1'b0;
        end

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (complete) begin
            if (slot_free) begin
                word_d       = shift_val;
                word_valid_d = 1'b1;
                frame_end_d  = last_word;
            end else begin
                // Set takes priority over a simultaneous clear.
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            shreg_q      <= '0;
            sym_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_end_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sym_cnt_q    <= sym_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_end_q  <= frame_end_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign frame_end  = frame_end_q;
    assign overrun    = overrun_q;
    assign in_frame   = (state_q == StCollect);

endmodule

// File: doc/dibit_frame_receiver.md
Name: dibit_frame_receiver

Overview:
- Receive side of the 2-bit registered symbol bus that our transmit-side blocks drive.
- Hunts for a sync word in the incoming dibit stream, then assembles the following symbols into fixed-length frames of WORD_W-bit words.
- Presents each word on a single-entry valid/ready output register and flags overruns.
- Sits between the 2-bit link and a byte-wide consumer (FIFO or register file).

Parameters:
- WORD_W, 8: output word width in bits; even, >= 4; WORD_W/2 symbols per word.
- SYNC, 8'hD5: sync pattern, WORD_W bits; must be nonzero.
- FRAME_LEN, 4: data words per frame after sync, >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- sym_valid  input  1  sym carries a symbol this cycle.
- sym  input  2  symbol; bit 1 is the earlier (more significant) bit.
- word  output  WORD_W  assembled data word.
- word_valid  output  1  word holds an unconsumed word.
- word_ready  input  1  consumer accepts word when word_valid=1.
- frame_end  output  1  qualifies word; high with the last word of a frame.
- in_frame  output  1  high while in COLLECT.
- overrun  output  1  sticky; a completed word was dropped.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at clk edge): state=HUNT, shift register=0, symbol/word counters=0, word=0, word_valid=0, frame_end=0, in_frame=0, overrun=0. Applies mid-frame; a partial word is discarded, a pending output word is lost.
- Cycles with sym_valid=0 change no datapath state; the handshake and clr_overrun still act.
- Symbols are shifted in MSB-first: shreg <= {shreg[WORD_W-3:0], sym}.
- HUNT:
  - Every valid symbol shifts into shreg.
  - If the post-shift value equals SYNC, go to COLLECT at that edge with symbol count=0, word count=0, shreg cleared.
  - in_frame=0.
- COLLECT:
  - in_frame=1.
  - Every valid symbol shifts into shreg and increments the symbol count.
  - The symbol that makes the count WORD_W/2 completes a word.
  - Sync patterns are not detected in COLLECT.
- Word completion on the edge with the completing symbol (latency 1 clk from that symbol to word_valid):
  - If the output slot is free (word_valid=0, or word_valid=1 and word_ready=1 this cycle): word <= post-shift value, word_valid <= 1, frame_end <= (word count == FRAME_LEN-1).
  - Otherwise: word, word_valid and frame_end are unchanged, and overrun <= 1. The dropped word still counts toward FRAME_LEN.
  - Symbol count <= 0, shreg <= 0, word count += 1.
  - On the FRAME_LEN-th word, go to HUNT and reset word count to 0. The next sync needs WORD_W/2 fresh symbols.
- Handshake:
  - A word transfers on any edge with word_valid=1 and word_ready=1.
  - After a transfer with no simultaneous completion, word_valid <= 0 and frame_end <= 0.
  - word and frame_end are stable while word_valid=1 and not accepted.
  - word_ready while word_valid=0 has no effect.
- overrun:
  - Set as above; cleared by clr_overrun=1.
  - A set and a clear on the same edge leave overrun=1 (set wins).
- Counters do not wrap within a frame; the word count is bounded by FRAME_LEN.

Test Plan:
- Reset, hold rst_n=0 for 2 clks, drive symbols -> all outputs 0, state HUNT.
- Defaults, word_ready=1:
  - Drive 3,1,1,1 -> in_frame=1 one edge after the 4th symbol.
  - Then 2,2,1,1 -> word=8'hA5, word_valid=1 for 1 clk starting 1 clk after the last symbol, frame_end=0.
- Full frame with words A5,00,FF,3C, ready=1 -> 4 transfers; frame_end=1 only with 3C; in_frame drops at the 3C completion edge.
- word_ready=0 after sync, 2 words sent -> word stays 8'hA5, overrun=1 after the 2nd completion.
- Then clr_overrun=1 together with a 3rd completion -> overrun stays 1.
- Completion edge coincident with word_ready=1 accepting the previous word -> no overrun; new word appears next cycle with word_valid continuously high.
- Reset mid-frame:
  - rst_n=0 after 2 data symbols -> in_frame=0.
  - Then symbols 2,2,1,1 -> no word_valid, because a sync is required first.
- Random sym_valid gaps of 0-3 cycles inside sync and data -> same words and frame_end as the gapless run.
